// File: rtl/andn_vector_source.sv
// Stimulus source for an N-input AND gate: sweeps every input vector (binary count)
// or every nonzero vector (LFSR) over a valid/ready stream, with the expected output alongside.
module andn_vector_source #(
    parameter int unsigned N    = 8,
    parameter int unsigned SEED = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic         abort,
    input  logic         mode,
    output logic [N-1:0] a_out,
    output logic         y_expected,
    output logic         valid,
    input  logic         ready,
    output logic         done,
    output logic [N:0]   vec_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    // Tap masks, one set bit per tap position.
    function automatic logic [7:0] tap_mask(input int unsigned n);
        case (n)
            4:       tap_mask = 8'h0C;
            5:       tap_mask = 8'h14;
            6:       tap_mask = 8'h30;
            7:       tap_mask = 8'h60;
            default: tap_mask = 8'hB8;
        endcase
    endfunction

    localparam logic [7:0]   TAPS_ALL  = tap_mask(N);
    localparam logic [N-1:0] TAPS      = TAPS_ALL[N-1:0];
    localparam logic [N-1:0] SEED_V    = SEED[N-1:0];
    localparam logic [N:0]   LAST_BIN  = {1'b0, {N{1'b1}}};
    localparam logic [N:0]   LAST_LFSR = LAST_BIN - (N+1)'(1);

    state_t       r_state;
    logic [N-1:0] r_a;
    logic         r_valid;
    logic         r_done;
    logic [N:0]   r_count;
    logic         r_mode;

    logic         w_fb;
    logic [N-1:0] w_next;
    logic         w_hs;
    logic         w_last;
    logic         w_load;

    always_comb begin
        w_fb   = ^(r_a & TAPS);
        w_next = r_mode ? {r_a[N-2:0], w_fb} : r_a + N'(1);
        w_hs   = r_valid & ready;
        w_last = r_mode ? (r_count == LAST_LFSR) : (r_count == LAST_BIN);
        w_load = start & ~abort & ((r_state == S_IDLE) | (r_state == S_DONE));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            r_count <= '0;
            r_mode  <= 1'b0;
        end else if (w_load) begin
            r_state <= S_RUN;
            r_mode  <= mode;
            r_count <= '0;
            r_a     <= mode ? SEED_V : '0;
            r_valid <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_RUN: begin
                    // The final vector is not advanced, so a_out keeps the last value emitted.
                    if (w_hs) begin
                        r_count <= r_count + (N+1)'(1);
                        if (!w_last) begin
                            r_a <= w_next;
                        end
                    end
                    if (abort) begin
                        r_state <= S_IDLE;
                        r_valid <= 1'b0;
                        r_done  <= 1'b0;
                    end else if (w_hs && w_last) begin
                        r_state <= S_DONE;
                        r_valid <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (abort) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b0;
                    end
                end
                S_IDLE: begin
                    r_valid <= 1'b0;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_valid <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign a_out      = r_a;
    assign y_expected = &r_a;
    assign valid      = r_valid;
    assign done       = r_done;
    assign vec_count  = r_count;

endmodule

// File: doc/andn_vector_source.md
ANDN_VECTOR_SOURCE -- requirements
Module: andn_vector_source

Interface
REQ-001 The block SHALL have parameter N, default 8, meaning vector width; legal range 4..8.
REQ-002 The block SHALL have parameter SEED, default 1, meaning the LFSR start value; it must be nonzero and fit in N bits.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-004 The block SHALL have port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit: begin a sweep.
REQ-006 The block SHALL have port abort, input, 1 bit: terminate a sweep.
REQ-007 The block SHALL have port mode, input, 1 bit: 0 = binary count, 1 = LFSR; sampled only on an accepted start.
REQ-008 The block SHALL have port a_out, output, N bits: the current stimulus vector.
REQ-009 The block SHALL have port y_expected, output, 1 bit: the reduction AND of a_out.
REQ-010 The block SHALL have port valid, output, 1 bit: a_out and y_expected are valid.
REQ-011 The block SHALL have port ready, input, 1 bit: the consumer accepts the current vector.
REQ-012 The block SHALL have port done, output, 1 bit: the sweep is complete (level).
REQ-013 The block SHALL have port vec_count, output, N+1 bits: number of vectors accepted in the current or last sweep.

Function
REQ-014 The block SHALL implement the states IDLE, RUN and DONE.
REQ-015 IDLE: a start with abort low SHALL go to RUN, latch mode, clear vec_count, and load the first vector (0 in count mode, SEED in LFSR mode). valid SHALL rise on the next cycle.
REQ-016 RUN: valid SHALL be 1.
REQ-017 A handshake SHALL occur when valid && ready on a rising clk edge.
REQ-018 While ready=0, a_out and y_expected SHALL hold stable.
REQ-019 On each handshake, vec_count SHALL increment by 1 and a_out SHALL advance to the next vector in the same edge.
REQ-020 Count mode SHALL step a_out +1 and emit 2^N vectors, 0 through 2^N-1, with no wrap emitted.
REQ-021 LFSR mode SHALL use a Fibonacci shift-left with feedback into bit 0 equal to the XOR of the tap bits: N=4 {3,2}; N=5 {4,2}; N=6 {5,4}; N=7 {6,5}; N=8 {7,5,4,3}.
REQ-022 LFSR mode SHALL emit 2^N-1 vectors, all nonzero, starting at SEED.
REQ-023 The handshake on the final vector SHALL go to DONE next cycle with valid=0 and done=1. vec_count SHALL read 2^N (count mode) or 2^N-1 (LFSR mode) and hold.
REQ-024 DONE: done SHALL be 1. start SHALL restart exactly as from IDLE, and done SHALL drop on the same edge that valid rises.
REQ-025 start while in RUN SHALL be ignored.
REQ-026 abort in RUN or DONE SHALL go to IDLE on the next edge with valid=0 and done=0. vec_count SHALL hold its value and a_out SHALL hold its last value.
REQ-027 abort and start asserted together SHALL resolve in favour of abort.
REQ-028 abort and a handshake in the same cycle SHALL count the handshake, then go to IDLE.
REQ-029 y_expected SHALL be purely combinational from the registered a_out, and 1 only when a_out equals all ones.
REQ-030 The vec_count width of N+1 bits SHALL hold 2^N without overflow.

Reset
REQ-031 reset_n=0 SHALL immediately, without waiting for clk, force state=IDLE, a_out=0, y_expected=0, valid=0, done=0, vec_count=0, and latched mode=0.
REQ-032 Reset asserted mid-sweep SHALL discard the sweep. After release, the block SHALL wait in IDLE for start.
REQ-033 The block SHALL act on no clk edge while reset_n=0.

Verification
REQ-034 N=8, mode=0, start pulse, ready tied 1 -> a_out SHALL be 0x00 on the first valid cycle with y_expected=0, reach 0xFF with y_expected=1 at the 256th vector, and show done=1 and vec_count=256 one cycle later.
REQ-035 N=8, mode=0, ready=0 for 3 cycles on vector 0x05 -> a_out SHALL stay 0x05 for all 3 cycles with vec_count unchanged, and advance to 0x06 after ready returns to 1.
REQ-036 N=4, mode=1, SEED=1, ready=1 -> the sequence SHALL be 0x1, 0x2, 0x4, 0x9, 0x3, ... with 15 distinct nonzero vectors, then done=1 and vec_count=15.
REQ-037 reset_n pulled low at vector 0x40 between clk edges -> valid and a_out SHALL go to 0 before the next edge. After release, valid SHALL stay 0 until start.
REQ-038 abort and start asserted together in RUN at vec_count=10 -> next cycle the block SHALL be in IDLE with valid=0 and done=0 and vec_count=10 (11 if a handshake occurred that cycle). A later start SHALL restart from 0x00.
REQ-039 start asserted in DONE -> done SHALL fall, valid SHALL rise with a_out=0, and vec_count SHALL clear, all on the same edge.
